fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with branch/stall priority and the IF/ID pipeline register.
// Memory read is combinational on imem_addr_o; decode sees the registered word one cycle later.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_inc;
  logic        squash;

  assign pc_inc      = pc + 32'd4;
  assign squash      = flush_i | branch_taken_i;
  assign imem_addr_o = pc;
  assign instr_op_o  = instr_o[31:26];

  // A taken branch wins over stall so the redirect can never be dropped.
  always_comb begin
    pc_next = pc_inc;
    if (branch_taken_i) begin
      pc_next = {branch_target_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Squash beats stall: a flushed slot becomes a bubble even while the PC is frozen.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= 32'd0;
      valid_o    <= 1'b0;
    end else if (squash) begin
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= 32'd0;
      valid_o    <= 1'b0;
    end else if (!stall_i) begin
      instr_o    <= imem_data_i;
      pc_plus4_o <= pc_inc;
      valid_o    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a spec model pushes expected outputs to a queue
// as each cycle's stimulus is driven; each test pops and compares after the clock edge.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pp4;
    logic        valid;
  } snap_t;

  logic        clk_i;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  int    checks = 0;
  int    errors = 0;
  snap_t expQ[$];
  snap_t model;
  snap_t got;
  snap_t want;

  fetch_stage dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .instr_o         (instr_o),
    .instr_op_o      (instr_op_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o)
  );

  // Memory word at address n is 32'h2000_0000 + n.
  assign imem_data_i = 32'h2000_0000 + imem_addr_o;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic snap_t observe();
    snap_t s;
    s.pc    = imem_addr_o;
    s.instr = instr_o;
    s.op    = instr_op_o;
    s.pp4   = pc_plus4_o;
    s.valid = valid_o;
    return s;
  endfunction

  function automatic snap_t resetSnap();
    snap_t s;
    s = '0;
    return s;
  endfunction

  // Drives one cycle of inputs, predicts the post-edge outputs, then advances past the edge.
  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
    snap_t nx;
    stall_i         = st;
    flush_i         = fl;
    branch_taken_i  = br;
    branch_target_i = tgt;
    nx = model;
    if (br)       nx.pc = tgt & 32'hFFFF_FFFC;
    else if (!st) nx.pc = model.pc + 32'd4;
    if (fl || br) begin
      nx.instr = 32'h0; nx.pp4 = 32'h0; nx.valid = 1'b0;
    end else if (!st) begin
      nx.instr = 32'h2000_0000 + model.pc;
      nx.pp4   = model.pc + 32'd4;
      nx.valid = 1'b1;
    end
    nx.op = nx.instr[31:26];
    model = nx;
    expQ.push_back(nx);
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model = resetSnap();
  endtask

  task automatic test_reset();
    stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 0;
    rst_n = 1'b0;
    #12;
    expQ.push_back(resetSnap());
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h want %h", got, want);
    end
    model = resetSnap();
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0);
      want = expQ.pop_front();
      got  = observe();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL seq_%0d: got %h want %h", i, got, want);
      end
      checks++;
      if (instr_o !== 32'h2000_0000 + 32'(4 * i) || pc_plus4_o !== 32'(4 * i + 4) || valid_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL seq_const_%0d: instr=%h pp4=%h valid=%b want instr=%h pp4=%h valid=1",
                 i, instr_o, pc_plus4_o, valid_o, 32'h2000_0000 + 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    void'(expQ.pop_front());
    void'(expQ.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0);
      want = expQ.pop_front();
      got  = observe();
      checks++;
      if (got !== want || imem_addr_o !== 32'h8 || instr_o !== 32'h2000_0004 || pc_plus4_o !== 32'h8) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got %h want %h", i, got, want);
      end
    end
    drive(0, 0, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'hC || instr_o !== 32'h2000_0008) begin
      errors++;
      $display("[TB] FAIL stall_resume: got %h want %h", got, want);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 32'h0);
    void'(expQ.pop_front());
    drive(0, 0, 1, 32'h0000_0043);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h40 || valid_o !== 1'b0 || instr_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL branch_redirect: got %h want %h", got, want);
    end
    drive(0, 0, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || instr_o !== 32'h2000_0040 || valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_target_fetch: got %h want %h", got, want);
    end
  endtask

  task automatic test_flush();
    drive(0, 1, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h48 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_alone: got %h want %h", got, want);
    end
    drive(0, 0, 0, 32'h0);
    void'(expQ.pop_front());
    drive(1, 1, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h4C || valid_o !== 1'b0 || pc_plus4_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_with_stall: got %h want %h", got, want);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 1, 32'h0000_0080);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h80 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL all_events: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1, 32'h0000_0100);
    void'(expQ.pop_front());
    drive(0, 0, 1, 32'h0000_0200);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h200 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_branch: got %h want %h", got, want);
    end
  endtask

  task automatic test_wrap_reset();
    drive(0, 0, 1, 32'hFFFF_FFFC);
    void'(expQ.pop_front());
    drive(0, 0, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h0 || pc_plus4_o !== 32'h0 || instr_o !== 32'h1FFF_FFFC) begin
      errors++;
      $display("[TB] FAIL pc_wrap: got %h want %h", got, want);
    end
    stall_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 32'h0000_0300;
    rst_n = 1'b0;
    #2;
    expQ.push_back(resetSnap());
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h want %h", got, want);
    end
    rst_n = 1'b1;
    model = resetSnap();
    drive(0, 0, 0, 32'h0);
    want = expQ.pop_front();
    got  = observe();
    checks++;
    if (got !== want || imem_addr_o !== 32'h4 || instr_o !== 32'h2000_0000 || valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_fetch: got %h want %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush();
    test_simultaneous();
    test_back_to_back();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
